// File: rtl/bus_ctrl_6809_pkg.sv
// bus_ctrl_6809_pkg: phase encodings and default memory-map constants for the 6809E bus controller
package bus_ctrl_6809_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    localparam logic [15:0] DEF_IO_BASE      = 16'hD800;
    localparam logic [15:0] DEF_ROM_BASE     = 16'hE000;
    localparam int          DEF_IO_CHANNELS  = 4;
    localparam int          DEF_IO_SPAN_LOG2 = 8;
    localparam int          DEF_WAIT_W       = 3;
    localparam int          DEF_BANK_W       = 2;

    // One past the last I/O byte, kept 17 bits wide so a window ending at $FFFF still compares correctly.
    function automatic logic [16:0] io_end(logic [15:0] base, int channels, int span_log2);
        return {1'b0, base} + 17'(channels << span_log2);
    endfunction

endpackage

// File: rtl/bus_ctrl_clkgen.sv
// bus_ctrl_clkgen: E/Q quadrature phase counter with wait-state and ready stretching of E-high
module bus_ctrl_clkgen
    import bus_ctrl_6809_pkg::*;
#(
    parameter int WAIT_W = DEF_WAIT_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [WAIT_W-1:0] wait_val,
    input  logic              ready,
    output logic              eclk,
    output logic              qclk,
    output logic              stretch,
    output logic              e_fall,
    output phase_t            phase
);

    phase_t            phase_nx;
    logic [WAIT_W-1:0] cnt, cnt_nx;
    logic              stretch_nx;
    logic              hold;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase   <= P0;
            cnt     <= '0;
            stretch <= 1'b0;
        end else begin
            phase   <= phase_nx;
            cnt     <= cnt_nx;
            stretch <= stretch_nx;
        end
    end

    // P3 repeats while wait states remain or the device is not ready.
    always_comb begin
        phase_nx   = phase;
        cnt_nx     = cnt;
        stretch_nx = stretch;
        hold       = (cnt != '0) || !ready;
        case (phase)
            P0: phase_nx = P1;
            P1: begin
                phase_nx = P2;
                cnt_nx   = wait_val;
            end
            P2: phase_nx = P3;
            P3: begin
                phase_nx   = hold ? P3 : P0;
                stretch_nx = hold;
                cnt_nx     = cnt - WAIT_W'(cnt != '0);
            end
            default: phase_nx = P0;
        endcase
    end

    assign eclk   = (phase == P2) || (phase == P3);
    assign qclk   = (phase == P1) || (phase == P2);
    assign e_fall = (phase == P3) && !hold;

endmodule

// File: rtl/bus_ctrl_6809.sv
// bus_ctrl_6809: 6809E E/Q clocks, RAM/ROM/I-O decode and per-region wait states.
// Define BUSCTRL_BANK_EN to turn the last I/O channel into a write-only ROM bank register.
module bus_ctrl_6809
    import bus_ctrl_6809_pkg::*;
#(
    parameter logic [15:0]                     IO_BASE      = DEF_IO_BASE,
    parameter int                              IO_CHANNELS  = DEF_IO_CHANNELS,
    parameter int                              IO_SPAN_LOG2 = DEF_IO_SPAN_LOG2,
    parameter logic [15:0]                     ROM_BASE     = DEF_ROM_BASE,
    parameter int                              WAIT_W       = DEF_WAIT_W,
    parameter logic [IO_CHANNELS*WAIT_W-1:0]   IO_WAITS     = '0,
    parameter logic [WAIT_W-1:0]               ROM_WAIT     = '0,
    parameter int                              BANK_W       = DEF_BANK_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [15:0]            i_addr,
    input  logic                   i_rw,
    input  logic [7:0]             i_data,
    input  logic                   i_ready,
    output logic                   o_eclk,
    output logic                   o_qclk,
    output logic                   o_ramcs_n,
    output logic                   o_romcs_n,
    output logic [IO_CHANNELS-1:0] o_iord_n,
    output logic [IO_CHANNELS-1:0] o_iowr_n,
    output logic                   o_stretch,
    output logic [BANK_W-1:0]      o_rom_bank
);

    localparam logic [16:0] IO_END = io_end(IO_BASE, IO_CHANNELS, IO_SPAN_LOG2);
    localparam int          CH_W   = IO_CHANNELS > 1 ? $clog2(IO_CHANNELS) : 1;

    if (IO_END > {1'b0, ROM_BASE} || IO_CHANNELS < 1 || IO_CHANNELS > 8 ||
        (IO_CHANNELS & (IO_CHANNELS - 1)) != 0) begin : g_bad_map
        $error("bus_ctrl_6809: I/O window overlaps ROM or IO_CHANNELS is not a power of 2 in 1..8");
    end

    logic                   in_io;
    logic [15:0]            io_off;
    logic [CH_W-1:0]        ch;
    logic [IO_CHANNELS-1:0] io_sel, strb_sel;
    logic [WAIT_W-1:0]      wait_val;
    logic                   e_fall;
    phase_t                 phase;
    logic                   unused_ok;

    assign o_ramcs_n = !(i_addr < IO_BASE);
    assign o_romcs_n = !(i_addr >= ROM_BASE);
    assign in_io     = (i_addr >= IO_BASE) && ({1'b0, i_addr} < IO_END);
    assign io_off    = i_addr - IO_BASE;
    assign ch        = CH_W'(io_off >> IO_SPAN_LOG2);
    assign io_sel    = in_io ? IO_CHANNELS'(1) << ch : '0;
    assign wait_val  = !o_romcs_n ? ROM_WAIT : in_io ? IO_WAITS[ch*WAIT_W +: WAIT_W] : '0;

    bus_ctrl_clkgen #(.WAIT_W(WAIT_W)) u_clkgen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .wait_val  (wait_val),
        .ready     (i_ready),
        .eclk      (o_eclk),
        .qclk      (o_qclk),
        .stretch   (o_stretch),
        .e_fall    (e_fall),
        .phase     (phase)
    );

`ifdef BUSCTRL_BANK_EN
    assign strb_sel = io_sel & ~(IO_CHANNELS'(1) << (IO_CHANNELS - 1));

    // Data from the CPU is valid at the falling edge of E, so latch on P3->P0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_rom_bank <= '0;
        else if (e_fall && io_sel[IO_CHANNELS-1] && !i_rw)
            o_rom_bank <= i_data[BANK_W-1:0];
    end
`else
    assign strb_sel   = io_sel;
    assign o_rom_bank = '0;
`endif

    assign o_iord_n  = ~(strb_sel & {IO_CHANNELS{o_eclk & i_rw}});
    assign o_iowr_n  = ~(strb_sel & {IO_CHANNELS{o_eclk & !i_rw}});
    assign unused_ok = ^{i_data, phase, e_fall};

endmodule

// File: tb/tb_bus_ctrl_6809.sv
// tb_bus_ctrl_6809: randomized and directed checks of bus_ctrl_6809 against a clock-position reference model
module tb_bus_ctrl_6809;

    localparam int IOB  = 'hD800;
    localparam int ROMB = 'hE000;
    localparam int NCH  = 4;
    localparam int SPAN = 256;
    localparam int ROM_W = 2;
`ifdef BUSCTRL_BANK_EN
    localparam bit BANK = 1'b1;
`else
    localparam bit BANK = 1'b0;
`endif

    logic        i_clk = 1'b0, i_reset_n = 1'b0, i_rw = 1'b1, i_ready = 1'b1;
    logic [15:0] i_addr = '0;
    logic [7:0]  i_data = '0;
    logic        o_eclk, o_qclk, o_ramcs_n, o_romcs_n, o_stretch;
    logic [3:0]  o_iord_n, o_iowr_n;
    logic [1:0]  o_rom_bank;

    int ch_wait[4] = '{2, 3, 1, 0};
    int t = 0, rem = 0;
    logic [1:0] m_bank = '0;
    int n_tests = 0, n_fail = 0;
    int e_cnt, s_cnt, rd1_cnt, wr0_cnt;
    logic smp_e, smp_q;

    bus_ctrl_6809 #(.IO_WAITS(12'h05A), .ROM_WAIT(3'd2)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_addr(i_addr), .i_rw(i_rw),
        .i_data(i_data), .i_ready(i_ready), .o_eclk(o_eclk), .o_qclk(o_qclk),
        .o_ramcs_n(o_ramcs_n), .o_romcs_n(o_romcs_n), .o_iord_n(o_iord_n),
        .o_iowr_n(o_iowr_n), .o_stretch(o_stretch), .o_rom_bank(o_rom_bank)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h addr=%04h t=%0d", tag, got, exp, i_addr, t);
        end
    endtask

    function automatic int chan_of(int a);
        return (a >= IOB && a < IOB + NCH * SPAN) ? (a - IOB) / SPAN : -1;
    endfunction

    function automatic int wait_of(int a);
        if (a >= ROMB) return ROM_W;
        if (chan_of(a) >= 0) return ch_wait[chan_of(a)];
        return 0;
    endfunction

    // t counts clocks since the start of the bus cycle: E is high from t=2 until the cycle ends.
    task automatic compare_all();
        bit e = t >= 2;
        bit q = t == 1 || t == 2;
        int k = chan_of(int'(i_addr));
        logic [3:0] rd = '1;
        logic [3:0] wr = '1;
        if (k >= 0 && e && !(BANK && k == NCH - 1)) begin
            if (i_rw) rd[k] = 1'b0;
            else wr[k] = 1'b0;
        end
        check("eclk", o_eclk, e);
        check("qclk", o_qclk, q);
        check("stretch", o_stretch, t >= 4);
        check("ramcs_n", o_ramcs_n, !(int'(i_addr) < IOB));
        check("romcs_n", o_romcs_n, !(int'(i_addr) >= ROMB));
        check("iord_n", o_iord_n, rd);
        check("iowr_n", o_iowr_n, wr);
        check("rom_bank", o_rom_bank, m_bank);
    endtask

    task automatic model_step();
        if (!i_reset_n) begin
            t = 0; rem = 0; m_bank = '0;
        end else if (t == 0) t = 1;
        else if (t == 1) begin
            t = 2; rem = wait_of(int'(i_addr));
        end else if (t == 2) t = 3;
        else if (rem > 0 || !i_ready) begin
            t++;
            if (rem > 0) rem--;
        end else begin
            if (BANK && chan_of(int'(i_addr)) == NCH - 1 && !i_rw) m_bank = i_data[1:0];
            t = 0;
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        compare_all();
        smp_e = o_eclk;
        smp_q = o_qclk;
        if (o_eclk) e_cnt++;
        if (o_stretch) s_cnt++;
        if (!o_iord_n[1]) rd1_cnt++;
        if (!o_iowr_n[0]) wr0_cnt++;
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic align();
        i_ready = 1'b1;
        for (int i = 0; i < 20 && t != 0; i++) tick();
        if (t != 0) check("align_timeout", t, 0);
    endtask

    task automatic zero_counts();
        e_cnt = 0; s_cnt = 0; rd1_cnt = 0; wr0_cnt = 0;
    endtask

    initial begin
        int qi, ei, r;
        #1;
        compare_all();
        tick();
        tick();
        i_reset_n = 1'b1;

        qi = -1; ei = -1;
        zero_counts();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (smp_q && qi < 0) qi = i;
            if (smp_e && ei < 0) ei = i;
        end
        check("q_leads_e", ei - qi, 1);
        check("e_duty_8clk", e_cnt, 4);

        align();
        i_addr = 16'hD900; i_rw = 1'b1;
        zero_counts();
        repeat (8) tick();
        check("d900_ehigh", e_cnt, 5);
        check("d900_stretch", s_cnt, 3);
        check("d900_iord1", rd1_cnt, 5);

        align();
        i_addr = 16'hD800; i_rw = 1'b0;
        zero_counts();
        repeat (3) tick();
        i_ready = 1'b0;
        repeat (6) tick();
        i_ready = 1'b1;
        repeat (2) tick();
        check("d800_ehigh", e_cnt, 8);
        check("d800_iowr0", wr0_cnt, 8);

        align();
        i_addr = 16'hD900; i_rw = 1'b1;
        repeat (5) tick();
        #2;
        check("pre_rst_stretch", o_stretch, 1);
        i_reset_n = 1'b0;
        #1;
        check("rst_eclk", o_eclk, 0);
        check("rst_qclk", o_qclk, 0);
        check("rst_stretch", o_stretch, 0);
        check("rst_iord", o_iord_n, 4'hF);
        check("rst_iowr", o_iowr_n, 4'hF);
        t = 0; rem = 0; m_bank = '0;
        tick();
        i_reset_n = 1'b1;

        align();
        i_addr = 16'hDB00; i_rw = 1'b0; i_data = 8'h5A;
        repeat (4) tick();
        check("bank_after_write", o_rom_bank, BANK ? 2'b10 : 2'b00);
        i_rw = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 4000; i++) begin
            if (t == 0 || $urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 3);
                i_addr = r == 0 ? 16'($urandom) : r == 1 ? 16'(IOB + $urandom_range(0, 'h3FF)) :
                         r == 2 ? 16'($urandom_range('hDC00, 'hDFFF)) : 16'($urandom_range(ROMB, 'hFFFF));
            end
            i_rw    = 1'($urandom);
            i_ready = $urandom_range(0, 9) != 0;
            i_data  = 8'($urandom);
            tick();
        end

        i_ready = 1'b1;
        for (int a = 0; a < 65536; a++) begin
            i_addr = 16'(a);
            i_rw   = i_addr[0] ^ i_addr[9];
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
